// File: rtl/bcd_calc_sequencer.sv
// bcd_calc_sequencer: digit-serial packed-BCD add/subtract sequencer driving
// one shared single-digit BCD adder, least significant digit first.
// Optional build macro BCD_SEQ_SIGN_MAG_EN: a subtract borrow is converted to
// sign/magnitude by an extra FIX pass (neg=1); otherwise the borrow is flagged
// on ovf and the 10's-complement wrap is left in result.
module bcd_calc_sequencer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf,
    output logic                  neg,
    output logic                  err
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             op_q;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [3:0]       x_dig_c;
    logic [3:0]       y_dig_c;
    logic [4:0]       sum_c;
    logic [3:0]       dig_c;
    logic             cout_c;

    // True if any nibble of v is not a legal BCD digit.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Shared one-digit BCD adder; operands selected by the current pass.
    always_comb begin
        x_dig_c = a_q[4*int'(idx) +: 4];
        y_dig_c = op_q ? (4'd9 - b_q[4*int'(idx) +: 4]) : b_q[4*int'(idx) +: 4];
        if (state == FIX) begin
            x_dig_c = 4'd0;
            y_dig_c = 4'd9 - result[4*int'(idx) +: 4];
        end
        sum_c  = 5'(x_dig_c) + 5'(y_dig_c) + 5'(carry);
        cout_c = (sum_c > 5'd9);
        dig_c  = cout_c ? 4'(sum_c - 5'd10) : sum_c[3:0];
    end

    // Sequencer state, operand latches and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
`ifdef BCD_SEQ_SIGN_MAG_EN
            neg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a_bcd;
                        b_q    <= b_bcd;
                        op_q   <= op;
                        result <= '0;
                        ovf    <= 1'b0;
                        err    <= 1'b0;
`ifdef BCD_SEQ_SIGN_MAG_EN
                        neg    <= 1'b0;
`endif
                        ready  <= 1'b0;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= '0;
                        carry <= op_q;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[4*int'(idx) +: 4] <= dig_c;
                    carry <= cout_c;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        if (!op_q) begin
                            ovf   <= cout_c;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (!cout_c) begin
`ifdef BCD_SEQ_SIGN_MAG_EN
                            idx   <= '0;
                            carry <= 1'b1;
                            state <= FIX;
`else
                            ovf   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FIX: begin
`ifdef BCD_SEQ_SIGN_MAG_EN
                    result[4*int'(idx) +: 4] <= dig_c;
                    carry <= cout_c;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        neg   <= 1'b1;
                        ovf   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`else
                    state <= IDLE;
                    ready <= 1'b1;
`endif
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef BCD_SEQ_SIGN_MAG_EN
    assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Directed self-checking bench for bcd_calc_sequencer (DIGITS=4).
// Cycle numbering: cycle n ends at rising edge n, so a registered output that
// changes at edge T+k is visible in cycle T+k+1. done in cycle T+6 therefore
// means done first seen just after edge T+5.
module tb_bcd_calc_sequencer;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a_bcd;
    logic [W-1:0] b_bcd;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         neg;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_calc_sequencer #(.DIGITS(DIGITS)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .neg      (neg),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one request and check latency (edges after T until done) and outputs.
    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_ovf, input logic exp_neg, input logic exp_err,
                          input int exp_edges);
        int n;
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        start = 1'b1;
        op    = o;
        a_bcd = a;
        b_bcd = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_bcd = 16'h9999;
        b_bcd = 16'h8888;
        op    = ~o;
        check({tag, "_ready_busy"}, 32'(ready), 32'd0);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_edges));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flags"}, {29'd0, ovf, neg, err}, {29'd0, exp_ovf, exp_neg, exp_err});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, done, ready}, {30'd0, 1'b0, 1'b1});
        check({tag, "_result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_bcd = '0;
        b_bcd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {26'd0, ready, done, ovf, neg, err, (result != 0)},
              {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;

        run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
        run_op("add_wrap",  1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
        run_op("add_prop",  1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
        run_op("sub_pos",   1'b1, 16'h0500, 16'h0123, 16'h0377, 1'b0, 1'b0, 1'b0, 5);
        run_op("sub_zero",  1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
`ifdef BCD_SEQ_SIGN_MAG_EN
        run_op("sub_neg",   1'b1, 16'h0123, 16'h0500, 16'h0377, 1'b0, 1'b1, 1'b0, 9);
        run_op("sub_neg1",  1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 9);
`else
        run_op("sub_neg",   1'b1, 16'h0123, 16'h0500, 16'h9623, 1'b1, 1'b0, 1'b0, 5);
        run_op("sub_neg1",  1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, 1'b0, 5);
`endif
        run_op("bad_b",     1'b0, 16'h1234, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 1);

        // Invalid digit with a second start raised during CHECK.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_bcd = 16'h12A4;
        b_bcd = 16'h0001;
        @(posedge clk);
        #1;
        a_bcd = 16'h1111;
        b_bcd = 16'h2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("inv_done", {29'd0, done, err, ready}, {29'd0, 1'b1, 1'b1, 1'b0});
        check("inv_result", 32'(result), 32'h0);
        n_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("inv_second_ignored", 32'(n_done), 32'd0);
        check("inv_held", {30'd0, err, ready}, {30'd0, 1'b1, 1'b1});

        // Reset asserted in cycle T+3 (sampled at edge T+3) while RUN is active.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_bcd = 16'h4321;
        b_bcd = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_abort", {26'd0, ready, done, ovf, neg, err, (result != 0)},
              {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        n_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        run_op("after_rst", 1'b0, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
